// File: rtl/DataTypes.sv
// Shared UART types and default constants; the transmitter uses the same
// package, hence the RX_ prefix on the receiver state enumerators.
package DataTypes;

  localparam int UART_BAUD_DIV  = 16;
  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } RX_STATE;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rxd pin plus a falling-edge
// detector; all flops reset to 1 so an idle line never produces a fall.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rxd_i,
  output logic level_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rxd_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  // A line held low keeps prev_q at 0, so it cannot retrigger.
  assign level_o = sync_q;
  assign fall_o  = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit start validation, LSB-first data sampling, stop check.
// Optional even-parity bit compiled in with `define UART_RX_PARITY_EN.
module uart_rx
  import DataTypes::*;
#(
  parameter int BAUD_DIV  = UART_BAUD_DIV,
  parameter int DATA_BITS = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  input  logic                 clr_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_ready,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 parity_error,
  output logic                 busy,
  output logic [2:0]           dbg_state_o
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(BAUD_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  logic rx_level;
  logic rx_fall;

  uart_rx_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .rxd_i   (rxd),
    .level_o (rx_level),
    .fall_o  (rx_fall)
  );

  RX_STATE              state_q;
  logic [CW-1:0]        cnt_q;
  logic [IW-1:0]        idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_ready_q;
  logic                 fe_q;
  logic                 ov_q;
  logic                 busy_q;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit_q;
  logic                 pe_q;
`endif

  // Host interface: rx_ready is a level held until clr_rx; a completing frame
  // in the same cycle as clr_rx wins and its flags replace the old ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RX_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_ready_q <= 1'b0;
      fe_q       <= 1'b0;
      ov_q       <= 1'b0;
      busy_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q  <= 1'b0;
      pe_q       <= 1'b0;
`endif
    end else begin
      if (clr_rx) begin
        rx_ready_q <= 1'b0;
        fe_q       <= 1'b0;
        ov_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
        pe_q       <= 1'b0;
`endif
      end
      cnt_q <= cnt_q + 1'b1;
      case (state_q)
        RX_IDLE: begin
          cnt_q <= '0;
          if (rx_fall) begin
            state_q <= RX_START;
            busy_q  <= 1'b1;
          end
        end
        RX_START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q <= '0;
            if (rx_level) begin
              state_q <= RX_IDLE;
              busy_q  <= 1'b0;
            end else begin
              idx_q   <= '0;
              state_q <= RX_DATA;
            end
          end
        end
        RX_DATA: begin
          if (cnt_q == CNT_FULL) begin
            cnt_q   <= '0;
            shift_q <= {rx_level, shift_q[DATA_BITS-1:1]};
            idx_q   <= idx_q + 1'b1;
            if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_q <= RX_PARITY;
`else
              state_q <= RX_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        RX_PARITY: begin
          if (cnt_q == CNT_FULL) begin
            cnt_q     <= '0;
            par_bit_q <= rx_level;
            state_q   <= RX_STOP;
          end
        end
`endif
        RX_STOP: begin
          // Returning to idle at mid-stop leaves room for a back-to-back start.
          if (cnt_q == CNT_FULL) begin
            cnt_q      <= '0;
            state_q    <= RX_IDLE;
            busy_q     <= 1'b0;
            rx_data_q  <= shift_q;
            rx_ready_q <= 1'b1;
            fe_q       <= ~rx_level | (fe_q & ~clr_rx);
            ov_q       <= (rx_ready_q | ov_q) & ~clr_rx;
`ifdef UART_RX_PARITY_EN
            pe_q       <= (^shift_q ^ par_bit_q) | (pe_q & ~clr_rx);
`endif
          end
        end
        default: begin
          state_q <= RX_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_ready      = rx_ready_q;
  assign framing_error = fe_q;
  assign overrun       = ov_q;
  assign busy          = busy_q;
  assign dbg_state_o   = state_q;
`ifdef UART_RX_PARITY_EN
  assign parity_error  = pe_q;
`else
  assign parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are pushed to an expected queue when
// driven and popped when the receiver leaves RX_STOP.
module tb_uart_rx;
  import DataTypes::*;

  localparam int B = 16;
  localparam int D = 8;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  // Pin edge to completion: 2 synchronizer clocks + 1 to enter RX_START,
  // half a bit to the start sample, then data (+parity) + stop bits.
  localparam int LAT = 3 + B / 2 + (D + 1 + P) * B;
  localparam int W = D + 3;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         rxd = 1'b1;
  logic         clr_rx = 1'b0;
  logic [D-1:0] rx_data;
  logic         rx_ready;
  logic         framing_error;
  logic         overrun;
  logic         parity_error;
  logic         busy;
  logic [2:0]   dbg_state;

  logic [W-1:0] exp_q[$];
  int           start_q[$];
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  logic [2:0]   prev_st = 3'd0;
  logic         seen;

  uart_rx #(.BAUD_DIV(B), .DATA_BITS(D)) dut (
    .clk           (clk),
    .reset         (reset),
    .rxd           (rxd),
    .clr_rx        (clr_rx),
    .rx_data       (rx_data),
    .rx_ready      (rx_ready),
    .framing_error (framing_error),
    .overrun       (overrun),
    .parity_error  (parity_error),
    .busy          (busy),
    .dbg_state_o   (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL timeout observed=no_finish expected=finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: a completion is the RX_STOP -> RX_IDLE transition
  always @(negedge clk) begin
    logic [W-1:0] e;
    int s;
    if (reset && prev_st == 3'(RX_STOP) && dbg_state == 3'(RX_IDLE)) begin
      chk("frame_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        s = start_q.pop_front();
        chk("rx_data", 32'(rx_data), 32'(e[W-1:3]));
        chk("rx_ready", 32'(rx_ready), 1);
        chk("framing_error", 32'(framing_error), 32'(e[2]));
        chk("overrun", 32'(overrun), 32'(e[1]));
        chk("parity_error", 32'(parity_error), 32'(e[0]));
        chk("busy_fall", 32'(busy), 0);
        chk("latency", 32'(cyc - s), 32'(LAT));
      end
    end
    prev_st = dbg_state;
  end

  // driver tasks; called on a negedge, return on a negedge
  task automatic send_frame(input logic [D-1:0] d, input logic stop_b, input logic bad_par,
                            input logic clr_done, input logic e_fe, input logic e_ov,
                            input logic e_pe);
    int st;
    st = cyc;
    exp_q.push_back({d, e_fe, e_ov, e_pe});
    start_q.push_back(st);
    rxd = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < D; i++) begin
      rxd = d[i];
      repeat (B) @(negedge clk);
    end
    if (P == 1) begin
      rxd = ^d ^ bad_par;
      repeat (B) @(negedge clk);
    end
    rxd = stop_b;
    for (int k = 0; k < B; k++) begin
      clr_rx = (clr_done && cyc == st + LAT - 1);
      @(negedge clk);
    end
    clr_rx = 1'b0;
    rxd = 1'b1;
    chk("frame_done", 32'(exp_q.size()), 0);
  endtask

  task automatic pulse_clr();
    clr_rx = 1'b1;
    @(negedge clk);
    clr_rx = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [D-1:0] part;
    part = 8'h96;
    repeat (3) @(negedge clk);
    chk("reset_rx_data", 32'(rx_data), 0);
    chk("reset_rx_ready", 32'(rx_ready), 0);
    chk("reset_framing", 32'(framing_error), 0);
    chk("reset_overrun", 32'(overrun), 0);
    chk("reset_parity", 32'(parity_error), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_state", 32'(dbg_state), 32'(RX_IDLE));
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // normal frame
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("normal_busy_idle", 32'(busy), 0);
    chk("normal_ready_held", 32'(rx_ready), 1);

    // false start: 4 low clocks, busy must pulse, nothing received
    pulse_clr();
    seen = 1'b0;
    for (int k = 0; k < 28; k++) begin
      rxd = (k < 4) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    chk("false_busy_pulse", 32'(seen), 1);
    chk("false_busy_idle", 32'(busy), 0);
    chk("false_ready", 32'(rx_ready), 0);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // framing error, then clear
    pulse_clr();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    pulse_clr();
    chk("clr_ready", 32'(rx_ready), 0);
    chk("clr_framing", 32'(framing_error), 0);
    chk("clr_overrun", 32'(overrun), 0);
    chk("clr_keeps_data", 32'(rx_data), 32'h3C);
    pulse_clr();
    chk("clr_idle_data", 32'(rx_data), 32'h3C);

    // overrun back-to-back, then again with clr on the completion cycle
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("overrun_sticky", 32'(overrun), 1);
    pulse_clr();
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("clr_done_ready", 32'(rx_ready), 1);
    chk("clr_done_overrun", 32'(overrun), 0);

    // reset during data bit 3
    rxd = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rxd = part[i];
      repeat (B) @(negedge clk);
    end
    rxd = part[3];
    repeat (B / 2) @(negedge clk);
    chk("midframe_busy", 32'(busy), 1);
    reset = 1'b0;
    #1;
    chk("midrst_rx_data", 32'(rx_data), 0);
    chk("midrst_ready", 32'(rx_ready), 0);
    chk("midrst_overrun", 32'(overrun), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_state", 32'(dbg_state), 32'(RX_IDLE));
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef UART_RX_PARITY_EN
    // 0x07 with correct even parity, then with the parity bit flipped
    pulse_clr();
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
`endif

    repeat (B) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
